// File: rtl/key_buffer_ctrl_if.sv
// key_buffer_ctrl_if: producer/consumer handshake bundle for key_buffer_ctrl.
// Handshakes:
//   - A keypoint transfers in any cycle where i_kp_valid and o_kp_ready are
//     both high. o_flag marks that cycle toward the shift buffer.
//   - A head entry is consumed in any cycle where o_pop_ack is high.
//     o_pop_ack is only ever high together with i_pop_req. o_hit marks that
//     cycle toward the shift buffer.
//   - All four returned strobes are combinational and have zero latency.
interface key_buffer_ctrl_if;
    logic i_kp_valid;
    logic o_kp_ready;
    logic i_pop_req;
    logic o_pop_ack;
    logic o_flag;
    logic o_hit;

    // Producer, matcher and buffer side.
    modport master (
        output i_kp_valid,
        output i_pop_req,
        input  o_kp_ready,
        input  o_pop_ack,
        input  o_flag,
        input  o_hit
    );

    // Controller side.
    modport slave (
        input  i_kp_valid,
        input  i_pop_req,
        output o_kp_ready,
        output o_pop_ack,
        output o_flag,
        output o_hit
    );
endinterface

// File: rtl/key_buffer_ctrl.sv
// key_buffer_ctrl: occupancy tracker and insert/advance scheduler for the
// keypoint shift buffer. Each frame is sequenced IDLE -> FILL -> DRAIN.
// A frame start that arrives while a frame is still open is held as pending.
// When the drain completes, the block then re-enters FILL directly instead of
// returning to IDLE.
// Optional feature: define KEY_BUF_DROP_CNT_EN to build the saturating
// per-frame drop counter. When it is undefined, o_drop_cnt reads 0.
module key_buffer_ctrl #(
    parameter int DEPTH = 100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_frame_end,
    key_buffer_ctrl_if.slave bus,
    output logic [9:0]  o_count,
    output logic        o_full,
    output logic        o_empty,
    output logic [1:0]  o_state,
    output logic        o_drain_done,
    output logic [15:0] o_drop_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [9:0] DEPTH_C = 10'(DEPTH);

    logic [1:0] state_q, state_d;
    logic [9:0] count_q, count_d;
    logic       pending_q, pending_d;
    logic       drain_done_q, drain_done_d;

    logic full, empty;
    logic pop_ack, kp_ready, flag;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == 10'd0);

    // Zero-latency handshake decode from the registered state and count.
    always_comb begin
        pop_ack  = 1'b0;
        kp_ready = 1'b0;
        if (state_q == FILL || state_q == DRAIN) begin
            pop_ack = bus.i_pop_req & ~empty;
        end
        if (state_q == FILL) begin
            // A full buffer still takes a keypoint when the head leaves in the same cycle.
            kp_ready = ~full | pop_ack;
        end
    end

    assign flag           = bus.i_kp_valid & kp_ready;
    assign bus.o_pop_ack  = pop_ack;
    assign bus.o_kp_ready = kp_ready;
    assign bus.o_flag     = flag;
    assign bus.o_hit      = pop_ack;

    // Frame sequencing and occupancy bookkeeping.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        drain_done_d = 1'b0;
        unique case ({flag, pop_ack})
            2'b10:   count_d = count_q + 10'd1;
            2'b01:   count_d = count_q - 10'd1;
            default: count_d = count_q;
        endcase
        case (state_q)
            IDLE: begin
                if (i_frame_start) begin
                    state_d = FILL;
                    count_d = 10'd0;
                end
            end
            FILL: begin
                // A start inside FILL closes the current frame and is remembered.
                if (i_frame_start) pending_d = 1'b1;
                if (i_frame_end || i_frame_start) state_d = DRAIN;
            end
            DRAIN: begin
                if (i_frame_start) pending_d = 1'b1;
                if (empty) begin
                    drain_done_d = 1'b1;
                    if (pending_q || i_frame_start) begin
                        state_d   = FILL;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, cleared asynchronously with the shift buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            count_q      <= 10'd0;
            pending_q    <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign o_count      = count_q;
    assign o_full       = full;
    assign o_empty      = empty;
    assign o_state      = state_q;
    assign o_drain_done = drain_done_q;

`ifdef KEY_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop_evt, frame_open;

    assign drop_evt   = (state_q == FILL || state_q == DRAIN) & bus.i_kp_valid & ~kp_ready;
    assign frame_open = ((state_q == IDLE) & i_frame_start) |
                        ((state_q == DRAIN) & empty & (pending_q | i_frame_start));

    // Saturating drop count. A new frame clears it, even if a drop lands in the same cycle.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (frame_open) begin
            drop_cnt_d = 16'd0;
        end else if (drop_evt && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) drop_cnt_q <= 16'd0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_key_buffer_ctrl.sv
// tb_key_buffer_ctrl: scoreboard bench for key_buffer_ctrl. The reference
// model keeps the buffer contents as a queue of keypoint ids.
module tb_key_buffer_ctrl;
    localparam int DEPTH = 100;
    localparam int W     = 35;

    logic        clk;
    logic        rst_n;
    logic        frame_start, frame_end;
    logic [9:0]  count;
    logic        full, empty, drain_done;
    logic [1:0]  state;
    logic [15:0] drop_cnt;

    key_buffer_ctrl_if bus();

    key_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_start(frame_start),
        .i_frame_end  (frame_end),
        .bus          (bus),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty),
        .o_state      (state),
        .o_drain_done (drain_done),
        .o_drop_cnt   (drop_cnt)
    );

    // Clock and counters.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];

    // Reference model: 0 idle, 1 fill, 2 drain. The buffer is a queue of ids.
    int m_mode  = 0;
    int m_buf[$];
    bit m_pend  = 0;
    int m_drops = 0;
    bit m_done  = 0;
    int m_next_id = 0;

    task automatic model_reset();
        m_mode = 0;
        m_buf.delete();
        m_pend = 0;
        m_drops = 0;
        m_done = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    // Driver: apply one cycle of inputs, queue the expected outputs, then advance the model.
    task automatic step(input bit fs, input bit fe, input bit kv, input bit pr);
        bit  ack, rdy, flg, done_n;
        int  sz;
        logic [15:0] exp_drop;
        frame_start    = fs;
        frame_end      = fe;
        bus.i_kp_valid = kv;
        bus.i_pop_req  = pr;
        sz  = m_buf.size();
        ack = (m_mode != 0) && pr && (sz > 0);
        rdy = (m_mode == 1) && ((sz < DEPTH) || ack);
        flg = kv && rdy;
`ifdef KEY_BUF_DROP_CNT_EN
        exp_drop = 16'(m_drops);
`else
        exp_drop = 16'd0;
`endif
        exp_q.push_back({flg, ack, rdy, ack, 2'(m_mode), 10'(sz),
                         (sz == DEPTH), (sz == 0), m_done, exp_drop});
        if (ack) void'(m_buf.pop_front());
        if (flg) begin
            m_buf.push_back(m_next_id);
            m_next_id++;
        end
        if ((m_mode != 0) && kv && !rdy && m_drops < 65535) m_drops++;
        done_n = 0;
        case (m_mode)
            0: if (fs) begin m_mode = 1; m_drops = 0; end
            1: begin
                if (fs) m_pend = 1;
                if (fs || fe) m_mode = 2;
            end
            default: begin
                if (fs) m_pend = 1;
                if (sz == 0) begin
                    done_n = 1;
                    if (m_pend) begin m_mode = 1; m_pend = 0; m_drops = 0; end
                    else m_mode = 0;
                end
            end
        endcase
        m_done = done_n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: compare every cycle that has a queued expectation, sampled mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("strobes{flag,hit,ready,ack}",
                32'({bus.o_flag, bus.o_hit, bus.o_kp_ready, bus.o_pop_ack}), 32'(e[34:31]));
            chk("status{state,count,full,empty,done}",
                32'({state, count, full, empty, drain_done}), 32'(e[30:16]));
            chk("drop_cnt", 32'(drop_cnt), 32'(e[15:0]));
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_drain_done"}, 32'(drain_done), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_strobes"}, 32'({bus.o_flag, bus.o_hit, bus.o_kp_ready, bus.o_pop_ack}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        frame_end = 1'b0;
        bus.i_kp_valid = 1'b0;
        bus.i_pop_req = 1'b0;
        #22;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, one rejected keypoint, then push and pop together at full.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Close the frame and drain it, with one drop during drain.
        step(0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, (i == 50), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Pop on an empty buffer.
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Short drain sequence.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);

        // Pending start: the start arrives in FILL at count 2.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Async reset mid-DRAIN at count 5.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_reset_state", 32'(state), 32'd2);
        chk("pre_reset_count", 32'(count), 32'd5);
        bus.i_kp_valid = 1'b1;
        bus.i_pop_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        bus.i_kp_valid = 1'b0;
        bus.i_pop_req = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45);
        end
        step(0, 1, 0, 0);
        for (int i = 0; i < DEPTH + 4; i++) step(0, 0, 0, 1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
